// File: rtl/matrix_mac_param_pkg.sv
// Shared definitions for the N x N matrix multiply-accumulate block:
// register map, STATUS bit positions and controller states.
package matrix_pkg;

  localparam logic [7:0] ADDR_A_PUSH   = 8'h00;
  localparam logic [7:0] ADDR_B_PUSH   = 8'h01;
  localparam logic [7:0] ADDR_INT_EN   = 8'h02;
  localparam logic [7:0] ADDR_OPSTART  = 8'h03;
  localparam logic [7:0] ADDR_CLEAR    = 8'h04;
  localparam logic [7:0] ADDR_STATUS   = 8'h05;
  localparam logic [7:0] ADDR_RES_IDX  = 8'h06;
  localparam logic [7:0] ADDR_RES_DATA = 8'h07;

  localparam int STAT_DONE   = 0;
  localparam int STAT_BUSY   = 1;
  localparam int STAT_A_FULL = 2;
  localparam int STAT_B_FULL = 3;
  localparam int STAT_ERR    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Accumulator width wide enough for N products of two DW-bit operands.
  function automatic int accw(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_mac_param_if.sv
// Register bus between the arbiter-side master and the matrix MAC slave.
interface matrix_mac_param_if;
  logic        s_sel;
  logic        s_wr;
  logic [7:0]  s_addr;
  logic [31:0] s_din;
  logic [31:0] s_dout;

  modport master (output s_sel, output s_wr, output s_addr, output s_din, input s_dout);
  modport slave  (input s_sel, input s_wr, input s_addr, input s_din, output s_dout);
endinterface

// File: rtl/mx_operand_buf.sv
// Row-major N*N operand store: push-only write pointer, full flag and one
// random-access read port used by the MAC datapath.
module mx_operand_buf #(
  parameter int N  = 2,
  parameter int DW = 8,
  localparam int NN = N * N,
  localparam int IW = $clog2(NN),
  localparam int PW = $clog2(NN + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic [IW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o
);

  logic [NN-1:0][DW-1:0] mem_q;
  logic [PW-1:0]         wptr_q;

  assign full_o  = (wptr_q == PW'(NN));
  assign rdata_o = mem_q[raddr_i];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                wptr_q <= '0;
    else if (clr_i)              wptr_q <= '0;
    else if (push_i && !full_o)  wptr_q <= wptr_q + 1'b1;
  end

  // Storage needs no reset: it is only read once the pointer reports full.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wptr_q[IW-1:0]] <= din_i;
  end

endmodule

// File: rtl/matrix_mac_param.sv
// Bus-programmed N x N unsigned matrix multiply: one MAC per cycle in
// i/j/k order, results held in C until the next run or reset.
module matrix_mac_param
  import matrix_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  matrix_mac_param_if.slave  bus,
  output logic               m_interrupt,
  output logic               op_done
);

  localparam int NN   = N * N;
  localparam int ACCW = accw(N, DW);
  localparam int IW   = $clog2(NN);
  localparam int CW   = $clog2(N);

  if (ACCW > 32) begin : g_accw_chk
    $error("matrix_mac_param: accumulator width exceeds 32 bits");
  end
  if (N < 2 || N > 8) begin : g_n_chk
    $error("matrix_mac_param: N must be in 2..8");
  end

  state_e                  state_q;
  logic [CW-1:0]           i_q, j_q, k_q;
  logic [ACCW-1:0]         acc_q;
  logic [NN-1:0][ACCW-1:0] c_q;
  logic                    done_q, err_q, op_done_q, int_en_q;
  logic [7:0]              res_idx_q;
  logic [31:0]             dout_q;

  logic          wr, rd, a_req, b_req, start, clr, busy, push_err;
  logic          a_full, b_full;
  logic [DW-1:0] a_rd, b_rd;
  logic [IW-1:0] a_ra, b_ra, c_wa;
  logic [2*DW-1:0] prod;
  logic [31:0]   status, rdata;
  logic          unused_din;

  assign wr    = bus.s_sel & bus.s_wr;
  assign rd    = bus.s_sel & ~bus.s_wr;
  assign a_req = wr && (bus.s_addr == ADDR_A_PUSH);
  assign b_req = wr && (bus.s_addr == ADDR_B_PUSH);
  assign start = wr && (bus.s_addr == ADDR_OPSTART) && bus.s_din[0];
  assign clr   = wr && (bus.s_addr == ADDR_CLEAR) && bus.s_din[0];
  assign busy  = (state_q == ST_CALC);
  assign push_err = (a_req && (busy || a_full)) || (b_req && (busy || b_full));
  assign unused_din = ^bus.s_din;

  mx_operand_buf #(.N(N), .DW(DW)) u_abuf (
    .clk(clk), .reset_n(reset_n), .clr_i(clr), .push_i(a_req && !busy),
    .din_i(bus.s_din[DW-1:0]), .raddr_i(a_ra), .rdata_o(a_rd), .full_o(a_full));

  mx_operand_buf #(.N(N), .DW(DW)) u_bbuf (
    .clk(clk), .reset_n(reset_n), .clr_i(clr), .push_i(b_req && !busy),
    .din_i(bus.s_din[DW-1:0]), .raddr_i(b_ra), .rdata_o(b_rd), .full_o(b_full));

  assign a_ra = IW'(i_q * N + k_q);
  assign b_ra = IW'(k_q * N + j_q);
  assign c_wa = IW'(i_q * N + j_q);
  assign prod = {{DW{1'b0}}, a_rd} * {{DW{1'b0}}, b_rd};

  always_comb begin
    status = '0;
    status[STAT_DONE]   = done_q;
    status[STAT_BUSY]   = busy;
    status[STAT_A_FULL] = a_full;
    status[STAT_B_FULL] = b_full;
    status[STAT_ERR]    = err_q;
  end

  always_comb begin
    rdata = '0;
    case (bus.s_addr)
      ADDR_INT_EN:   rdata = {31'b0, int_en_q};
      ADDR_STATUS:   rdata = status;
      ADDR_RES_IDX:  rdata = {24'b0, res_idx_q};
      ADDR_RES_DATA: if (res_idx_q < 8'(NN)) rdata = 32'(c_q[res_idx_q[IW-1:0]]);
      default:       rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      c_q       <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      op_done_q <= 1'b0;
      int_en_q  <= 1'b0;
      res_idx_q <= '0;
      dout_q    <= '0;
    end else begin
      op_done_q <= 1'b0;
      if (wr && bus.s_addr == ADDR_INT_EN)  int_en_q  <= bus.s_din[0];
      if (wr && bus.s_addr == ADDR_RES_IDX) res_idx_q <= bus.s_din[7:0];
      if (rd) dout_q <= rdata;
      // CLEAR wins over everything, including a run in progress.
      if (clr) begin
        state_q <= ST_IDLE;
        i_q     <= '0;
        j_q     <= '0;
        k_q     <= '0;
        acc_q   <= '0;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        if (push_err) err_q <= 1'b1;
        case (state_q)
          ST_IDLE: if (start) begin
            if (a_full && b_full) state_q <= ST_CALC;
            else                  err_q   <= 1'b1;
          end
          ST_CALC: begin
            if (k_q == CW'(N - 1)) begin
              c_q[c_wa] <= acc_q + ACCW'(prod);
              acc_q     <= '0;
              k_q       <= '0;
              if (j_q == CW'(N - 1)) begin
                j_q <= '0;
                if (i_q == CW'(N - 1)) begin
                  i_q       <= '0;
                  state_q   <= ST_DONE;
                  done_q    <= 1'b1;
                  op_done_q <= 1'b1;
                end else begin
                  i_q <= i_q + 1'b1;
                end
              end else begin
                j_q <= j_q + 1'b1;
              end
            end else begin
              acc_q <= acc_q + ACCW'(prod);
              k_q   <= k_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.s_dout  = dout_q;
  assign op_done     = op_done_q;
  assign m_interrupt = done_q & int_en_q;

endmodule

// File: tb/tb_matrix_mac_param.sv
// Randomized bench for matrix_mac_param: an N=2/DW=8 and an N=4/DW=12 instance
// checked against a plain triple-loop matrix product.
module tb_matrix_mac_param;

  localparam logic [7:0] R_A = 8'h00, R_B = 8'h01, R_IEN = 8'h02, R_START = 8'h03;
  localparam logic [7:0] R_CLR = 8'h04, R_STAT = 8'h05, R_IDX = 8'h06, R_DATA = 8'h07;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  matrix_mac_param_if bus0();
  matrix_mac_param_if bus1();
  logic od0, od1, irq0, irq1;

  matrix_mac_param #(.N(2), .DW(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .m_interrupt(irq0), .op_done(od0));
  matrix_mac_param #(.N(4), .DW(12)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .m_interrupt(irq1), .op_done(od1));

  int tests_run = 0;
  int fails = 0;
  int od_cnt0 = 0;
  int od_cnt1 = 0;
  int a_m[16];
  int b_m[16];
  longint c_m[16];
  longint got_c[16];

  always @(negedge clk) begin
    if (od0 === 1'b1) od_cnt0++;
    if (od1 === 1'b1) od_cnt1++;
  end

  // Reference: C = A x B, row-major, computed directly from the operands.
  function automatic void model(input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        longint s = 0;
        for (int k = 0; k < n; k++) s += longint'(a_m[i*n+k]) * longint'(b_m[k*n+j]);
        c_m[i*n+j] = s;
      end
  endfunction

  task automatic bwr(input int d, input logic [7:0] ad, input logic [31:0] dt);
    @(negedge clk);
    if (d == 0) begin bus0.s_sel = 1; bus0.s_wr = 1; bus0.s_addr = ad; bus0.s_din = dt; end
    else        begin bus1.s_sel = 1; bus1.s_wr = 1; bus1.s_addr = ad; bus1.s_din = dt; end
    @(negedge clk);
    bus0.s_sel = 0; bus1.s_sel = 0;
  endtask

  task automatic brd(input int d, input logic [7:0] ad, output logic [31:0] dt);
    @(negedge clk);
    if (d == 0) begin bus0.s_sel = 1; bus0.s_wr = 0; bus0.s_addr = ad; end
    else        begin bus1.s_sel = 1; bus1.s_wr = 0; bus1.s_addr = ad; end
    @(negedge clk);
    bus0.s_sel = 0; bus1.s_sel = 0;
    dt = (d == 0) ? bus0.s_dout : bus1.s_dout;
  endtask

  task automatic fill_rand(input int maxv);
    for (int i = 0; i < 16; i++) begin
      a_m[i] = int'($urandom_range(0, maxv));
      b_m[i] = int'($urandom_range(0, maxv));
    end
  endtask

  task automatic load(input int d, input int n);
    for (int i = 0; i < n*n; i++) bwr(d, R_A, 32'(a_m[i]));
    for (int i = 0; i < n*n; i++) bwr(d, R_B, 32'(b_m[i]));
  endtask

  // Writes OPSTART and returns cycles until op_done is seen (-1 on timeout).
  task automatic start_wait(input int d, output int cyc);
    bwr(d, R_START, 32'd1);
    cyc = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (((d == 0) ? od0 : od1) === 1'b1) begin cyc = c; break; end
    end
  endtask

  task automatic read_c(input int d, input int n);
    logic [31:0] v;
    for (int i = 0; i < n*n; i++) begin
      bwr(d, R_IDX, 32'(i));
      brd(d, R_DATA, v);
      got_c[i] = longint'(v);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    tests_run++;
    if (bus0.s_dout !== 32'd0 || od0 !== 1'b0 || irq0 !== 1'b0) begin
      fails++; $display("FAIL reset_outputs got dout=%0h od=%b irq=%b expected 0/0/0", bus0.s_dout, od0, irq0);
    end
    brd(0, R_STAT, v);
    tests_run++; if (v !== 32'h0) begin fails++; $display("FAIL reset_status got %0h expected 0", v); end
    brd(0, R_IEN, v);
    tests_run++; if (v !== 32'h0) begin fails++; $display("FAIL reset_int_en got %0h expected 0", v); end
    brd(0, R_DATA, v);
    tests_run++; if (v !== 32'h0) begin fails++; $display("FAIL reset_c0 got %0h expected 0", v); end
  endtask

  task automatic test_known();
    int exp_c[4] = '{316, 337, 376, 401};
    int cyc, n0;
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin a_m[i] = 10 + i; b_m[i] = 14 + i; end
    load(0, 2);
    n0 = od_cnt0;
    start_wait(0, cyc);
    tests_run++; if (cyc !== 8) begin fails++; $display("FAIL known_latency got %0d expected 8", cyc); end
    @(negedge clk);
    tests_run++; if (od0 !== 1'b0) begin fails++; $display("FAIL known_pulse_width got %b expected 0", od0); end
    brd(0, R_STAT, v);
    tests_run++; if (v !== 32'h0D) begin fails++; $display("FAIL known_status got %0h expected d", v); end
    read_c(0, 2);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got_c[i] !== longint'(exp_c[i])) begin
        fails++; $display("FAIL known_c%0d got %0d expected %0d", i, got_c[i], exp_c[i]);
      end
    end
    bwr(0, R_START, 32'd1);
    repeat (12) @(negedge clk);
    brd(0, R_STAT, v);
    tests_run++;
    if (v !== 32'h0D || od_cnt0 !== n0 + 1) begin
      fails++; $display("FAIL start_in_done got status=%0h pulses=%0d expected d/%0d", v, od_cnt0 - n0, 1);
    end
    bwr(0, R_IDX, 32'd4);
    brd(0, R_IDX, v);
    tests_run++; if (v !== 32'd4) begin fails++; $display("FAIL res_idx_rb got %0d expected 4", v); end
    brd(0, R_DATA, v);
    tests_run++; if (v !== 32'd0) begin fails++; $display("FAIL res_idx_oob got %0d expected 0", v); end
    bwr(0, R_IDX, 32'd3);
    brd(0, R_DATA, v);
    brd(0, 8'h20, v);
    tests_run++; if (v !== 32'd0) begin fails++; $display("FAIL unmapped_read got %0h expected 0", v); end
    bwr(0, R_CLR, 32'd1);
    brd(0, R_STAT, v);
    tests_run++; if (v !== 32'h0) begin fails++; $display("FAIL clear_status got %0h expected 0", v); end
    brd(0, R_DATA, v);
    tests_run++; if (v !== 32'd401) begin fails++; $display("FAIL clear_keeps_c got %0d expected 401", v); end
  endtask

  task automatic test_interrupt();
    int cyc;
    logic [31:0] v;
    bwr(0, R_CLR, 32'd1);
    bwr(0, R_IEN, 32'd1);
    brd(0, R_IEN, v);
    tests_run++; if (v !== 32'd1) begin fails++; $display("FAIL int_en_rb got %0h expected 1", v); end
    fill_rand(255);
    model(2);
    load(0, 2);
    tests_run++; if (irq0 !== 1'b0) begin fails++; $display("FAIL irq_before got %b expected 0", irq0); end
    start_wait(0, cyc);
    tests_run++;
    if (cyc !== 8 || irq0 !== 1'b1) begin fails++; $display("FAIL irq_with_done got cyc=%0d irq=%b expected 8/1", cyc, irq0); end
    repeat (5) @(negedge clk);
    tests_run++; if (irq0 !== 1'b1) begin fails++; $display("FAIL irq_level got %b expected 1", irq0); end
    read_c(0, 2);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got_c[i] !== c_m[i]) begin fails++; $display("FAIL irq_run_c%0d got %0d expected %0d", i, got_c[i], c_m[i]); end
    end
    bwr(0, R_CLR, 32'd1);
    brd(0, R_STAT, v);
    tests_run++;
    if (irq0 !== 1'b0 || v !== 32'h0) begin fails++; $display("FAIL irq_clear got irq=%b status=%0h expected 0/0", irq0, v); end
    bwr(0, R_IEN, 32'd0);
  endtask

  task automatic test_start_not_full();
    int n0;
    logic [31:0] v;
    bwr(0, R_CLR, 32'd1);
    for (int i = 0; i < 3; i++) bwr(0, R_A, 32'($urandom_range(0, 255)));
    n0 = od_cnt0;
    bwr(0, R_START, 32'd1);
    repeat (20) @(negedge clk);
    brd(0, R_STAT, v);
    tests_run++;
    if (v !== 32'h10 || od_cnt0 !== n0) begin
      fails++; $display("FAIL start_not_full got status=%0h pulses=%0d expected 10/0", v, od_cnt0 - n0);
    end
  endtask

  task automatic test_push_overflow();
    int cyc;
    logic [31:0] v;
    bwr(0, R_CLR, 32'd1);
    fill_rand(255);
    model(2);
    for (int i = 0; i < 4; i++) bwr(0, R_A, 32'(a_m[i]));
    bwr(0, R_A, 32'(a_m[0] ^ 8'hA5));
    brd(0, R_STAT, v);
    tests_run++; if (v !== 32'h14) begin fails++; $display("FAIL overflow_status got %0h expected 14", v); end
    for (int i = 0; i < 4; i++) bwr(0, R_B, 32'(b_m[i]));
    start_wait(0, cyc);
    tests_run++; if (cyc !== 8) begin fails++; $display("FAIL overflow_latency got %0d expected 8", cyc); end
    read_c(0, 2);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got_c[i] !== c_m[i]) begin fails++; $display("FAIL overflow_c%0d got %0d expected %0d", i, got_c[i], c_m[i]); end
    end
  endtask

  task automatic test_clear_mid();
    int cyc, n0;
    logic [31:0] v;
    bwr(0, R_CLR, 32'd1);
    fill_rand(255);
    load(0, 2);
    n0 = od_cnt0;
    bwr(0, R_START, 32'd1);
    repeat (2) @(negedge clk);
    bwr(0, R_CLR, 32'd1);
    brd(0, R_STAT, v);
    repeat (20) @(negedge clk);
    tests_run++;
    if (v !== 32'h0 || od_cnt0 !== n0) begin
      fails++; $display("FAIL clear_mid got status=%0h pulses=%0d expected 0/0", v, od_cnt0 - n0);
    end
    fill_rand(255);
    model(2);
    load(0, 2);
    start_wait(0, cyc);
    tests_run++; if (cyc !== 8) begin fails++; $display("FAIL rerun_latency got %0d expected 8", cyc); end
    read_c(0, 2);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got_c[i] !== c_m[i]) begin fails++; $display("FAIL rerun_c%0d got %0d expected %0d", i, got_c[i], c_m[i]); end
    end
  endtask

  task automatic test_reset_mid_calc();
    int n0;
    logic [31:0] v;
    bwr(0, R_CLR, 32'd1);
    fill_rand(255);
    a_m[0] = 200; b_m[0] = 200;
    load(0, 2);
    n0 = od_cnt0;
    bwr(0, R_START, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    brd(0, R_STAT, v);
    tests_run++;
    if (v !== 32'h0 || od_cnt0 !== n0) begin
      fails++; $display("FAIL reset_mid_calc got status=%0h pulses=%0d expected 0/0", v, od_cnt0 - n0);
    end
    brd(0, R_DATA, v);
    tests_run++; if (v !== 32'h0) begin fails++; $display("FAIL reset_clears_c got %0d expected 0", v); end
  endtask

  task automatic test_n4_max();
    int cyc;
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin a_m[i] = 4095; b_m[i] = 4095; end
    load(1, 4);
    start_wait(1, cyc);
    tests_run++; if (cyc !== 64) begin fails++; $display("FAIL n4_latency got %0d expected 64", cyc); end
    brd(1, R_STAT, v);
    tests_run++; if (v !== 32'h0D) begin fails++; $display("FAIL n4_status got %0h expected d", v); end
    read_c(1, 4);
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (got_c[i] !== 64'd67076100) begin fails++; $display("FAIL n4_max_c%0d got %0d expected 67076100", i, got_c[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int r = 0; r < 2; r++) begin
      bwr(1, R_CLR, 32'd1);
      fill_rand(4095);
      model(4);
      load(1, 4);
      start_wait(1, cyc);
      tests_run++; if (cyc !== 64) begin fails++; $display("FAIL b2b_latency run%0d got %0d expected 64", r, cyc); end
      read_c(1, 4);
      for (int i = 0; i < 16; i++) begin
        tests_run++;
        if (got_c[i] !== c_m[i]) begin fails++; $display("FAIL b2b_run%0d_c%0d got %0d expected %0d", r, i, got_c[i], c_m[i]); end
      end
    end
  endtask

  initial begin
    bus0.s_sel = 0; bus0.s_wr = 0; bus0.s_addr = '0; bus0.s_din = '0;
    bus1.s_sel = 0; bus1.s_wr = 0; bus1.s_addr = '0; bus1.s_din = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_known();
    test_interrupt();
    test_start_not_full();
    test_push_overflow();
    test_clear_mid();
    test_reset_mid_calc();
    test_n4_max();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete, expected finish before 2ms");
    $fatal(1);
  end

endmodule

// File: doc/matrix_mac_param.md
MATRIX_MAC_PARAM -- requirements
Module: matrix_mac_param

Interface
REQ-001 Parameter N, default 2, matrix dimension (legal 2..8, square N x N).
REQ-002 Parameter DW, default 8, unsigned operand width; ACCW = 2*DW + clog2(N) SHALL be <= 32 (elaboration error otherwise).
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 s_sel  input  1  bus slave select (from bus arbiter), qualifies every access.
REQ-006 s_wr  input  1  1 = write, 0 = read.
REQ-007 s_addr  input  8  register address.
REQ-008 s_din  input  32  write data.
REQ-009 s_dout  output  32  read data.
REQ-010 m_interrupt  output  1  level interrupt.
REQ-011 op_done  output  1  one-cycle completion pulse.

Function
REQ-012 Register map: 0x00 A_PUSH (W), 0x01 B_PUSH (W), 0x02 INT_EN bit0 (R/W), 0x03 OPSTART bit0 (W), 0x04 CLEAR bit0 (W), 0x05 STATUS (R), 0x06 RES_IDX (R/W), 0x07 RES_DATA (R); unmapped reads return 0, unmapped writes ignored.
REQ-013 A_PUSH/B_PUSH SHALL store s_din[DW-1:0] row-major at the buffer's write pointer and increment it; buffer full when count == N*N.
REQ-014 Push when full, or push while busy, SHALL be dropped and set STATUS.err.
REQ-015 STATUS bits: [0] done, [1] busy, [2] a_full, [3] b_full, [4] err, others 0.
REQ-016 FSM states IDLE, CALC, DONE; OPSTART bit0=1 in IDLE with both buffers full -> CALC; with either not full -> stay IDLE, set err.
REQ-017 OPSTART in CALC or DONE SHALL be ignored (no err).
REQ-018 CALC: one MAC per cycle, acc += A[i][k]*B[k][j], loop order i outer, j, k inner; at k==N-1 write acc+product to C[i][j] and restart acc at 0.
REQ-019 CALC SHALL last exactly N*N*N cycles; state DONE is entered on the following edge.
REQ-020 Entering DONE: op_done high for exactly one cycle, STATUS.done=1.
REQ-021 m_interrupt = done AND INT_EN.bit0, combinational from registered flags.
REQ-022 CLEAR bit0=1 in any state: FSM -> IDLE, both write pointers -> 0, done/err -> 0, i/j/k/acc -> 0; C contents and INT_EN retained; CLEAR during CALC aborts with no op_done.
REQ-023 DONE -> IDLE only via CLEAR; results stay readable in DONE.
REQ-024 RES_DATA read returns C[RES_IDX] (row-major index) zero-extended to 32; RES_IDX >= N*N returns 0.
REQ-025 Reads: s_dout registered, valid the cycle after s_sel=1, s_wr=0; holds last value otherwise.
REQ-026 Arithmetic unsigned, no saturation; ACCW guarantees no overflow.

Reset
REQ-027 reset_n low: FSM IDLE, pointers/counters/acc 0, INT_EN 0, RES_IDX 0, C array 0, s_dout 0, m_interrupt 0, op_done 0, STATUS 0.
REQ-028 Reset asserted mid-CALC SHALL abort immediately; no op_done after release.

Structure
REQ-029 Package matrix_pkg holds register address constants, STATUS bit positions, FSM state enum.
REQ-030 Sub-module mx_operand_buf (N*N x DW storage, write pointer, full flag, random read port) instantiated twice for A and B.

Verification
REQ-031 N=2, DW=8: push A 10,11,12,13, B 14,15,16,17, OPSTART -> op_done pulse 8 cycles after start; C = 316,337,376,401 via RES_IDX 0..3.
REQ-032 INT_EN=1 then full run -> m_interrupt rises with op_done, stays high; CLEAR -> m_interrupt 0, STATUS 0x0C (buffers still full? no: pointers cleared -> STATUS 0x00).
REQ-033 OPSTART with only 3 A words pushed -> stays IDLE, STATUS.err=1, no op_done.
REQ-034 Fifth A_PUSH at N=2 -> dropped, err=1, A contents unchanged in result.
REQ-035 CLEAR at cycle 3 of CALC -> STATUS.busy=0, no op_done; reload and rerun gives correct C.
REQ-036 N=4, DW=12, all operands 4095 -> each C = 4*4095*4095 = 67076100, no overflow, done after 64 CALC cycles.
